wb_arbiter: RTL and testbench

Writeback arbiter sitting directly downstream of the M/WB pipeline registers and the EX/WB result registers. It merges completed memory-pipe and ALU-pipe instructions onto the single ROB write port, one write per cycle. Losers are held in small per-source queues, and a stall is raised toward the source when its queue is full. Round-robin arbitration prevents either pipe from starving.

---
 rtl/wb_pkg.sv | 31 +++
 rtl/wb_fifo.sv | 45 ++++
 rtl/wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: queue entry layout, source ids and default queue depth.
// Width macros fall back to defaults when the surrounding build does not define them.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 5
`endif

package wb_pkg;

  localparam int WB_FIFO_DEPTH = 2;

  typedef enum logic {
    WB_SRC_MEM = 1'b0,
    WB_SRC_ALU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [`INSTR_TYPE_SZ-1:0]   instruction_type;
    logic [`WORD_SIZE-1:0]       pc;
    logic                        exception;
    logic [`WORD_SIZE-1:0]       virtual_addr;
    logic [`WORD_SIZE-1:0]       value;
    logic [`ROB_ENTRY_WIDTH-1:0] rob_id;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small per-source holding queue for writeback entries that lost arbitration.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH   = WB_FIFO_DEPTH,
  parameter type entry_t = wb_entry_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);

  entry_t         store [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // Payload storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_data;
  end

  assign head = store[rd_ptr];
  assign full = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/wb_arbiter.sv
// Merges memory-pipe and ALU-pipe completions onto the single ROB write port, round-robin on conflict.
// Optional WB_PERF_CNT_EN adds conflict and stall event counters.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int WORD_SIZE       = `WORD_SIZE,
  parameter int INSTR_TYPE_SZ   = `INSTR_TYPE_SZ,
  parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH,
  parameter int FIFO_DEPTH      = WB_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_valid,
  input  logic [INSTR_TYPE_SZ-1:0]   mem_instruction_type,
  input  logic [WORD_SIZE-1:0]       mem_pc,
  input  logic                       mem_exception,
  input  logic [WORD_SIZE-1:0]       mem_virtual_addr_exception,
  input  logic [WORD_SIZE-1:0]       mem_load_data,
  input  logic [ROB_ENTRY_WIDTH-1:0] mem_rob_id,
  output logic                       mem_stall,
  input  logic                       alu_valid,
  input  logic [INSTR_TYPE_SZ-1:0]   alu_instruction_type,
  input  logic [WORD_SIZE-1:0]       alu_pc,
  input  logic                       alu_exception,
  input  logic [WORD_SIZE-1:0]       alu_result,
  input  logic [ROB_ENTRY_WIDTH-1:0] alu_rob_id,
  output logic                       alu_stall,
  output logic                       rob_wr_valid,
  output logic [INSTR_TYPE_SZ-1:0]   rob_wr_instruction_type,
  output logic [WORD_SIZE-1:0]       rob_wr_pc,
  output logic                       rob_wr_exception,
  output logic [WORD_SIZE-1:0]       rob_wr_virtual_addr,
  output logic [WORD_SIZE-1:0]       rob_wr_value,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_wr_id
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]                perf_conflicts,
  output logic [31:0]                perf_mem_stalls,
  output logic [31:0]                perf_alu_stalls
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t       mem_in, alu_in, mem_head, alu_head, win_entry;
  logic [CW-1:0]   mem_count, alu_count;
  logic            mem_full, alu_full;
  logic            mem_has_q, alu_has_q, mem_live, alu_live;
  logic            mem_cand, alu_cand, contested, win_any;
  logic            mem_push, mem_pop, alu_push, alu_pop;
  wb_src_e         last_grant, win_src;

  assign mem_in = '{instruction_type: mem_instruction_type, pc: mem_pc,
                    exception: mem_exception, virtual_addr: mem_virtual_addr_exception,
                    value: mem_load_data, rob_id: mem_rob_id};
  assign alu_in = '{instruction_type: alu_instruction_type, pc: alu_pc,
                    exception: alu_exception, virtual_addr: '0,
                    value: alu_result, rob_id: alu_rob_id};

  // Stall comes from registered occupancy only, so a full queue popping this cycle still stalls.
  assign mem_stall = mem_full;
  assign alu_stall = alu_full;

  assign mem_has_q = (mem_count != '0);
  assign alu_has_q = (alu_count != '0);
  assign mem_live  = mem_valid && !mem_stall;
  assign alu_live  = alu_valid && !alu_stall;
  assign mem_cand  = mem_has_q || mem_live;
  assign alu_cand  = alu_has_q || alu_live;

  always_comb begin
    contested = mem_cand && alu_cand;
    win_any   = mem_cand || alu_cand;
    if (contested)     win_src = (last_grant == WB_SRC_ALU) ? WB_SRC_MEM : WB_SRC_ALU;
    else if (mem_cand) win_src = WB_SRC_MEM;
    else               win_src = WB_SRC_ALU;

    if (win_src == WB_SRC_MEM) win_entry = mem_has_q ? mem_head : mem_in;
    else                       win_entry = alu_has_q ? alu_head : alu_in;

    mem_pop  = win_any && (win_src == WB_SRC_MEM) && mem_has_q;
    alu_pop  = win_any && (win_src == WB_SRC_ALU) && alu_has_q;
    // A live input is queued unless it bypassed straight to the ROB port.
    mem_push = mem_live && !(win_any && (win_src == WB_SRC_MEM) && !mem_has_q);
    alu_push = alu_live && !(win_any && (win_src == WB_SRC_ALU) && !alu_has_q);
  end

  wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(wb_entry_t)) u_mem_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (mem_push),
    .push_data (mem_in),
    .pop       (mem_pop),
    .head      (mem_head),
    .count     (mem_count),
    .full      (mem_full)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(wb_entry_t)) u_alu_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (alu_push),
    .push_data (alu_in),
    .pop       (alu_pop),
    .head      (alu_head),
    .count     (alu_count),
    .full      (alu_full)
  );

  // ROB write port registers; payload holds its last value on idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rob_wr_valid            <= 1'b0;
      rob_wr_instruction_type <= '0;
      rob_wr_pc               <= '0;
      rob_wr_exception        <= 1'b0;
      rob_wr_virtual_addr     <= '0;
      rob_wr_value            <= '0;
      rob_wr_id               <= '0;
      last_grant              <= WB_SRC_ALU;
    end else begin
      rob_wr_valid <= win_any;
      if (win_any) begin
        rob_wr_instruction_type <= win_entry.instruction_type;
        rob_wr_pc               <= win_entry.pc;
        rob_wr_exception        <= win_entry.exception;
        rob_wr_virtual_addr     <= win_entry.virtual_addr;
        rob_wr_value            <= win_entry.value;
        rob_wr_id               <= win_entry.rob_id;
      end
      if (contested) last_grant <= win_src;
    end
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_conflicts  <= '0;
      perf_mem_stalls <= '0;
      perf_alu_stalls <= '0;
    end else begin
      if (contested) perf_conflicts  <= perf_conflicts + 32'd1;
      if (mem_stall) perf_mem_stalls <= perf_mem_stalls + 32'd1;
      if (alu_stall) perf_alu_stalls <= perf_alu_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: queue-based reference model checked every cycle plus literal spot checks.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int W = `WORD_SIZE;
  localparam int T = `INSTR_TYPE_SZ;
  localparam int R = `ROB_ENTRY_WIDTH;
  localparam int D = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         mem_valid, mem_exception, mem_stall;
  logic [T-1:0] mem_instruction_type;
  logic [W-1:0] mem_pc, mem_virtual_addr_exception, mem_load_data;
  logic [R-1:0] mem_rob_id;
  logic         alu_valid, alu_exception, alu_stall;
  logic [T-1:0] alu_instruction_type;
  logic [W-1:0] alu_pc, alu_result;
  logic [R-1:0] alu_rob_id;
  logic         rob_wr_valid, rob_wr_exception;
  logic [T-1:0] rob_wr_instruction_type;
  logic [W-1:0] rob_wr_pc, rob_wr_virtual_addr, rob_wr_value;
  logic [R-1:0] rob_wr_id;

  wb_arbiter #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_instruction_type(mem_instruction_type), .mem_pc(mem_pc),
    .mem_exception(mem_exception), .mem_virtual_addr_exception(mem_virtual_addr_exception),
    .mem_load_data(mem_load_data), .mem_rob_id(mem_rob_id), .mem_stall(mem_stall),
    .alu_valid(alu_valid), .alu_instruction_type(alu_instruction_type), .alu_pc(alu_pc),
    .alu_exception(alu_exception), .alu_result(alu_result), .alu_rob_id(alu_rob_id),
    .alu_stall(alu_stall),
    .rob_wr_valid(rob_wr_valid), .rob_wr_instruction_type(rob_wr_instruction_type),
    .rob_wr_pc(rob_wr_pc), .rob_wr_exception(rob_wr_exception),
    .rob_wr_virtual_addr(rob_wr_virtual_addr), .rob_wr_value(rob_wr_value), .rob_wr_id(rob_wr_id)
  );

  int n_vec = 0;
  int n_err = 0;

  wb_entry_t mq[$];
  wb_entry_t aq[$];
  bit        m_last_alu;
  logic      exp_valid;
  wb_entry_t exp_e;
  int        mem_arr[$];
  bit        saw_mem_stall;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    aq.delete();
    m_last_alu = 1'b1;
    exp_valid  = 1'b0;
    exp_e      = '0;
  endtask

  // Advance the reference one clock using the inputs currently driven.
  task automatic model_step();
    bit ms, as, ml, al, mc, ac, win_mem;
    wb_entry_t me, ae, w;
    ms = (mq.size() == D);
    as = (aq.size() == D);
    ml = mem_valid && !ms;
    al = alu_valid && !as;
    me = '{instruction_type: mem_instruction_type, pc: mem_pc, exception: mem_exception,
           virtual_addr: mem_virtual_addr_exception, value: mem_load_data, rob_id: mem_rob_id};
    ae = '{instruction_type: alu_instruction_type, pc: alu_pc, exception: alu_exception,
           virtual_addr: '0, value: alu_result, rob_id: alu_rob_id};
    mc = (mq.size() > 0) || ml;
    ac = (aq.size() > 0) || al;
    if (mc && ac) begin
      win_mem    = m_last_alu;
      m_last_alu = !win_mem;
    end else begin
      win_mem = mc;
    end
    exp_valid = mc || ac;
    if (mc || ac) begin
      if (win_mem) begin
        if (mq.size() > 0) begin
          w = mq.pop_front();
          if (ml) mq.push_back(me);
        end else w = me;
        if (al) aq.push_back(ae);
      end else begin
        if (aq.size() > 0) begin
          w = aq.pop_front();
          if (al) aq.push_back(ae);
        end else w = ae;
        if (ml) mq.push_back(me);
      end
      exp_e = w;
    end
  endtask

  task automatic check_outputs();
    chk("wr_valid", 64'(rob_wr_valid), 64'(exp_valid));
    chk("wr_type",  64'(rob_wr_instruction_type), 64'(exp_e.instruction_type));
    chk("wr_pc",    64'(rob_wr_pc), 64'(exp_e.pc));
    chk("wr_exc",   64'(rob_wr_exception), 64'(exp_e.exception));
    chk("wr_vaddr", 64'(rob_wr_virtual_addr), 64'(exp_e.virtual_addr));
    chk("wr_value", 64'(rob_wr_value), 64'(exp_e.value));
    chk("wr_id",    64'(rob_wr_id), 64'(exp_e.rob_id));
    chk("mem_stall", 64'(mem_stall), 64'(mq.size() == D));
    chk("alu_stall", 64'(alu_stall), 64'(aq.size() == D));
    if (rob_wr_valid && rob_wr_id >= 10 && rob_wr_id <= 15) mem_arr.push_back(int'(rob_wr_id));
    if (mem_stall) saw_mem_stall = 1'b1;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    mem_valid = 0; mem_exception = 0; mem_instruction_type = '0; mem_pc = '0;
    mem_virtual_addr_exception = '0; mem_load_data = '0; mem_rob_id = '0;
    alu_valid = 0; alu_exception = 0; alu_instruction_type = '0; alu_pc = '0;
    alu_result = '0; alu_rob_id = '0;
  endtask

  task automatic drive_mem(input logic [R-1:0] id, input logic [W-1:0] pc, input logic [W-1:0] data);
    mem_valid = 1; mem_rob_id = id; mem_pc = pc; mem_load_data = data;
    mem_instruction_type = T'(1); mem_exception = 0; mem_virtual_addr_exception = pc + 32'h100;
  endtask

  task automatic drive_alu(input logic [R-1:0] id, input logic [W-1:0] pc, input logic [W-1:0] data);
    alu_valid = 1; alu_rob_id = id; alu_pc = pc; alu_result = data;
    alu_instruction_type = T'(2); alu_exception = 0;
  endtask

  initial begin
    int mi, ai, guard;
    bit mem_acc, alu_acc;
    idle_inputs();
    reset = 1'b0;
    model_reset();
    saw_mem_stall = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(rob_wr_valid), 64'd0);
    chk("rst_id", 64'(rob_wr_id), 64'd0);
    chk("rst_mem_stall", 64'(mem_stall), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single memory op
    drive_mem(3, 42, 32'hAB);
    tick();
    chk("single_valid", 64'(rob_wr_valid), 64'd1);
    chk("single_id", 64'(rob_wr_id), 64'd3);
    chk("single_value", 64'(rob_wr_value), 64'hAB);
    chk("single_pc", 64'(rob_wr_pc), 64'd42);
    idle_inputs();
    tick();
    chk("single_after", 64'(rob_wr_valid), 64'd0);

    // First contest goes to memory, second to ALU
    drive_mem(1, 32'h200, 32'h11);
    drive_alu(2, 32'h300, 32'h22);
    tick();
    chk("contest1_first", 64'(rob_wr_id), 64'd1);
    idle_inputs();
    tick();
    chk("contest1_second", 64'(rob_wr_id), 64'd2);
    chk("contest1_second_v", 64'(rob_wr_valid), 64'd1);
    tick();
    drive_mem(4, 32'h400, 32'h44);
    drive_alu(5, 32'h500, 32'h55);
    tick();
    chk("contest2_first", 64'(rob_wr_id), 64'd5);
    idle_inputs();
    tick();
    chk("contest2_second", 64'(rob_wr_id), 64'd4);
    tick();

    // Exceptions on both pipes
    drive_mem(6, 32'h600, 32'hDEAD);
    mem_exception = 1;
    mem_virtual_addr_exception = 32'h1000;
    tick();
    chk("exc_flag", 64'(rob_wr_exception), 64'd1);
    chk("exc_vaddr", 64'(rob_wr_virtual_addr), 64'h1000);
    chk("exc_value", 64'(rob_wr_value), 64'hDEAD);
    idle_inputs();
    drive_alu(7, 32'h700, 32'h77);
    alu_exception = 1;
    tick();
    chk("alu_exc_vaddr", 64'(rob_wr_virtual_addr), 64'd0);
    idle_inputs();
    tick();

    // Back-pressure: upstream holds data while its stall is high
    mi = 0; ai = 0; guard = 0;
    while ((mi < 6 || ai < 8) && guard < 60) begin
      idle_inputs();
      if (mi < 6) drive_mem(R'(10 + mi), W'(32'h1000 + mi), W'(32'h100 + mi));
      if (ai < 8) drive_alu(R'(20 + ai), W'(32'h2000 + ai), W'(32'h200 + ai));
      mem_acc = mem_valid && (mq.size() < D);
      alu_acc = alu_valid && (aq.size() < D);
      tick();
      if (mem_acc) mi++;
      if (alu_acc) ai++;
      guard++;
    end
    if (guard >= 60) begin
      n_err++;
      $display("FAIL bp_timeout: got %0d/%0d accepted required 6/8", mi, ai);
    end
    idle_inputs();
    repeat (8) tick();
    chk("bp_saw_stall", 64'(saw_mem_stall), 64'd1);
    chk("bp_mem_count", 64'(mem_arr.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < mem_arr.size()) chk("bp_mem_order", 64'(mem_arr[i]), 64'(10 + i));
    end

    // Reset mid-stream with one entry in each queue
    drive_mem(8, 32'h800, 32'h88);
    drive_alu(9, 32'h900, 32'h99);
    tick();
    drive_mem(12, 32'hA00, 32'hAA);
    drive_alu(13, 32'hB00, 32'hBB);
    tick();
    chk("pre_rst_mq", 64'(mq.size()), 64'd1);
    chk("pre_rst_aq", 64'(aq.size()), 64'd1);
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("midrst_valid", 64'(rob_wr_valid), 64'd0);
    chk("midrst_pc", 64'(rob_wr_pc), 64'd0);
    chk("midrst_value", 64'(rob_wr_value), 64'd0);
    chk("midrst_id", 64'(rob_wr_id), 64'd0);
    chk("midrst_mstall", 64'(mem_stall), 64'd0);
    chk("midrst_astall", 64'(alu_stall), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_valid", 64'(rob_wr_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
